// File: rtl/sabertooth_packet_serial.sv
// Packetized-serial driver for daisy-chained Sabertooth controllers.
// Startup delay, autobaud byte, round-robin packets, watchdog stop, 8N1 TX.
module sabertooth_packet_serial #(
  parameter int NUM_CTRL       = 2,
  parameter int BASE_ADDR      = 128,
  parameter int BAUD_DIV       = 1250,
  parameter int STARTUP_CYCLES = 24000000,
  parameter int GAP_BITS       = 4,
  parameter int WD_CYCLES      = 6000000,
  localparam int NM            = 2 * NUM_CTRL,
  localparam int MW            = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                   clk_12MHz,
  input  logic                   reset,
  input  logic [16*NUM_CTRL-1:0] motors,
  input  logic                   update,
  input  logic                   pause,
  output logic                   tx,
  output logic                   busy,
  output logic                   timed_out,
  output logic                   packet_done,
  output logic [MW-1:0]          cur_motor
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int WW = (WD_CYCLES > 0) ? $clog2(WD_CYCLES + 1) : 1;
  localparam int GAP_LEN = GAP_BITS * BAUD_DIV;

  typedef enum logic [2:0] {
    S_STARTUP, S_AUTOBAUD, S_GAP, S_LOAD, S_SEND
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt;
  logic [1:0]      byte_idx;
  logic [7:0]      cmd_q, data_q, chk_q;
  logic [9:0]      shreg;
  logic [3:0]      bit_cnt;
  logic [BW-1:0]   baud_cnt;
  logic            bit_end, uart_last, uart_start;
  logic [7:0]      uart_data, next_byte;
  logic [7:0]      mval, v, addr_c, cmd_c, data_c, chk_c;
  logic [WW-1:0]   wd_cnt;

  // 8N1 shifter; a new byte may load in the last stop-bit cycle
  assign bit_end   = baud_cnt == BW'(BAUD_DIV - 1);
  assign uart_last = busy && bit_end && (bit_cnt == 4'd9);
  assign tx        = busy ? shreg[0] : 1'b1;

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      busy     <= 1'b0;
    end else if (uart_start && (!busy || uart_last)) begin
      shreg    <= {1'b1, uart_data, 1'b0};
      bit_cnt  <= '0;
      baud_cnt <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (update) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WW'(WD_CYCLES)) begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end

  assign timed_out = (WD_CYCLES != 0) && (wd_cnt == WW'(WD_CYCLES));

  always_comb begin
    mval = '0;
    for (int i = 0; i < NM; i++) begin
      if (cur_motor == MW'(i)) mval = motors[8*i +: 8];
    end
  end

  // v=255 is the only case where v-127 exceeds 127
  always_comb begin
    v      = (pause || timed_out) ? 8'd127 : mval;
    addr_c = 8'(BASE_ADDR) + 8'(cur_motor >> 1);
    if (v >= 8'd127) begin
      cmd_c  = {5'b0, cur_motor[0], 2'b00};
      data_c = (v == 8'd255) ? 8'd127 : v - 8'd127;
    end else begin
      cmd_c  = {5'b0, cur_motor[0], 2'b01};
      data_c = 8'd127 - v;
    end
    chk_c = {1'b0, addr_c[6:0] + cmd_c[6:0] + data_c[6:0]};
  end

  always_comb begin
    unique case (byte_idx)
      2'd0:    next_byte = cmd_q;
      2'd1:    next_byte = data_q;
      default: next_byte = chk_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    uart_start = 1'b0;
    uart_data  = 8'hAA;
    unique case (state_q)
      S_STARTUP: begin
        if (cnt == 32'(STARTUP_CYCLES - 1)) begin
          uart_start = 1'b1;
          state_d    = S_AUTOBAUD;
        end
      end
      S_AUTOBAUD: begin
        if (uart_last) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt == 32'(GAP_LEN - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        uart_start = 1'b1;
        uart_data  = addr_c;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (uart_last) begin
          if (byte_idx == 2'd3) begin
            state_d = S_GAP;
          end else begin
            uart_start = 1'b1;
            uart_data  = next_byte;
          end
        end
      end
      default: state_d = S_STARTUP;
    endcase
  end

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_STARTUP;
      cnt         <= '0;
      byte_idx    <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      cur_motor   <= '0;
      packet_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt         <= (state_d != state_q) ? '0 : cnt + 32'd1;
      packet_done <= 1'b0;
      if (state_q == S_LOAD) begin
        cmd_q    <= cmd_c;
        data_q   <= data_c;
        chk_q    <= chk_c;
        byte_idx <= '0;
      end
      if (state_q == S_SEND && uart_last) begin
        if (byte_idx == 2'd3) begin
          packet_done <= 1'b1;
          cur_motor   <= (cur_motor == MW'(NM - 1)) ?
                         '0 : cur_motor + MW'(1);
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sabertooth_packet_serial.sv
// Bench for sabertooth_packet_serial: UART receiver feeding a
// byte scoreboard, plus directed pause, watchdog and reset steps.
module tb_sabertooth_packet_serial;

  localparam int NUM_CTRL = 2;

  logic                   clk_12MHz = 1'b0;
  logic                   reset;
  logic [16*NUM_CTRL-1:0] motors;
  logic                   update;
  logic                   pause;
  logic                   tx, busy, timed_out, packet_done;
  logic [1:0]             cur_motor;

  sabertooth_packet_serial #(
    .NUM_CTRL(NUM_CTRL), .BASE_ADDR(128), .BAUD_DIV(4),
    .STARTUP_CYCLES(16), .GAP_BITS(4), .WD_CYCLES(50)
  ) dut (
    .clk_12MHz(clk_12MHz), .reset(reset), .motors(motors),
    .update(update), .pause(pause), .tx(tx), .busy(busy),
    .timed_out(timed_out), .packet_done(packet_done),
    .cur_motor(cur_motor)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  typedef struct packed {
    logic [7:0] data;
    int         delta;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   pd_cnt  = 0;
  int   last_st = 0;
  bit   kick;

  always @(posedge clk_12MHz) cyc <= cyc + 1;

  always @(negedge clk_12MHz)
    if (packet_done === 1'b1) pd_cnt <= pd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_12MHz);
    update = kick && (cyc % 20 == 0);
  endtask

  task automatic push_b(input logic [7:0] d, input int dl);
    exp_t e;
    e.data  = d;
    e.delta = dl;
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [7:0] a, input logic [7:0] c,
                          input logic [7:0] d, input logic [7:0] k);
    push_b(a, 57);
    push_b(c, 40);
    push_b(d, 40);
    push_b(k, 40);
  endtask

  task automatic wait_pd();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (packet_done === 1'b1) break;
    end
    chk("pd_seen", 32'(packet_done), 1);
  endtask

  task automatic wait_tx_low();
    for (int i = 0; i < 200; i++) begin
      if (tx === 1'b0) break;
      tick();
    end
  endtask

  // UART receiver: 4 samples per bit, all must agree
  initial begin
    logic [7:0] b;
    logic       v;
    bit         ok, abort;
    int         st;
    exp_t       e;
    forever begin
      @(negedge clk_12MHz);
      if (reset === 1'b1 && tx === 1'b0) begin
        st = cyc; ok = 1; abort = 0; b = '0; v = 1'b0;
        for (int bi = 0; bi < 10; bi++) begin
          for (int s = 0; s < 4; s++) begin
            if (!(bi == 0 && s == 0)) @(negedge clk_12MHz);
            if (reset !== 1'b1) begin
              abort = 1;
              break;
            end
            if (s == 0) v = tx;
            else if (tx !== v) ok = 0;
          end
          if (abort) break;
          if (bi >= 1 && bi <= 8) b[bi-1] = v;
          if (bi == 0 && v !== 1'b0) ok = 0;
          if (bi == 9 && v !== 1'b1) ok = 0;
        end
        if (!abort) begin
          chk("rx_frame", 32'(ok), 1);
          chk("rx_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_byte", 32'(b), 32'(e.data));
            if (e.delta != 0) chk("rx_spacing", 32'(st - last_st), 32'(e.delta));
          end
        end
        last_st = st;
      end
    end
  end

  initial begin
    int c, c2;
    reset  = 1'b0;
    update = 1'b0;
    pause  = 1'b0;
    kick   = 1;
    motors = {8'd127, 8'd200, 8'd0, 8'd255};
    repeat (3) @(negedge clk_12MHz);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timed_out", 32'(timed_out), 0);
    chk("rst_packet_done", 32'(packet_done), 0);
    chk("rst_cur_motor", 32'(cur_motor), 0);

    push_b(8'hAA, 0);
    push_pkt(8'h80, 8'h00, 8'h7F, 8'h7F);
    push_pkt(8'h80, 8'h05, 8'h7F, 8'h04);
    push_pkt(8'h81, 8'h00, 8'h49, 8'h4A);
    push_pkt(8'h81, 8'h04, 8'h00, 8'h05);
    tick();
    reset = 1'b1;
    c = cyc;
    wait_tx_low();
    chk("startup_idle", 32'(cyc - c), 16);
    for (int i = 0; i < 4; i++) begin
      wait_pd();
      chk("cur_motor_rr", 32'(cur_motor), 32'((i + 1) % 4));
    end
    tick();
    chk("pd_count", 32'(pd_cnt), 4);

    // pause applied in gap, released mid-packet
    push_pkt(8'h80, 8'h00, 8'h7F, 8'h7F);
    wait_pd();
    pause = 1'b1;
    push_pkt(8'h80, 8'h04, 8'h00, 8'h04);
    repeat (77) tick();
    pause = 1'b0;
    wait_pd();
    push_pkt(8'h81, 8'h00, 8'h49, 8'h4A);
    repeat (77) tick();
    pause = 1'b1;
    motors[23:16] = 8'd5;
    wait_pd();
    pause = 1'b0;
    motors[23:16] = 8'd200;
    push_pkt(8'h81, 8'h04, 8'h00, 8'h05);
    wait_pd();
    chk("cur_motor_wrap", 32'(cur_motor), 0);

    // watchdog expiry and stop packet
    push_pkt(8'h80, 8'h00, 8'h7F, 8'h7F);
    push_pkt(8'h80, 8'h04, 8'h00, 8'h04);
    kick = 0;
    update = 1'b1;
    tick();
    c = cyc;
    for (int i = 0; i < 200; i++) begin
      if (timed_out === 1'b1) break;
      tick();
    end
    chk("wd_expiry", 32'(cyc - c), 50);
    wait_pd();
    wait_pd();
    chk("wd_hold", 32'(timed_out), 1);
    push_pkt(8'h81, 8'h00, 8'h49, 8'h4A);
    update = 1'b1;
    tick();
    c2 = cyc;
    chk("wd_clear", 32'(timed_out), 0);
    repeat (49) tick();
    update = 1'b1;
    tick();
    chk("wd_race", 32'(timed_out), 0);
    kick = 1;
    push_pkt(8'h81, 8'h04, 8'h00, 8'h05);
    wait_pd();
    wait_pd();

    // async reset during data bit 3 of motor1's address byte
    push_pkt(8'h80, 8'h00, 8'h7F, 8'h7F);
    wait_pd();
    push_pkt(8'h80, 8'h05, 8'h7F, 8'h04);
    wait_tx_low();
    repeat (17) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cur_motor", 32'(cur_motor), 0);
    exp_q.delete();
    push_b(8'hAA, 0);
    push_pkt(8'h80, 8'h00, 8'h7F, 8'h7F);
    repeat (3) tick();
    tick();
    reset = 1'b1;
    c = cyc;
    wait_tx_low();
    chk("restart_idle", 32'(cyc - c), 16);
    wait_pd();
    chk("restart_cur_motor", 32'(cur_motor), 1);
    repeat (5) tick();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
